// File: rtl/rvh_l1d_ptw_req_arb_if.sv
// rvh_l1d_ptw_req_arb_if: walk, replay, L1D and response handshakes around the PTW request arbiter
interface rvh_l1d_ptw_req_arb_if #(
    parameter int PTW_ID_WIDTH = 4,
    parameter int PADDR_WIDTH  = 56
);
    logic                    ptw_req_vld_i;
    logic [PTW_ID_WIDTH-1:0] ptw_req_id_i;
    logic [PADDR_WIDTH-1:0]  ptw_req_paddr_i;
    logic                    ptw_req_rdy_o;
    logic                    ptw_walk_req_vld_o;
    logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id_o;
    logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr_o;
    logic                    replay_req_vld_i;
    logic [PTW_ID_WIDTH-1:0] replay_req_id_i;
    logic [PADDR_WIDTH-1:0]  replay_req_paddr_i;
    logic                    replay_req_rdy_o;
    logic                    l1d_req_vld_o;
    logic [PTW_ID_WIDTH-1:0] l1d_req_id_o;
    logic [PADDR_WIDTH-1:0]  l1d_req_paddr_o;
    logic                    l1d_req_is_replay_o;
    logic                    l1d_req_rdy_i;
    logic                    ptw_walk_resp_vld_i;
    logic                    ptw_walk_resp_rdy_i;

    modport master (
        output ptw_req_vld_i, ptw_req_id_i, ptw_req_paddr_i,
        output replay_req_vld_i, replay_req_id_i, replay_req_paddr_i,
        output l1d_req_rdy_i, ptw_walk_resp_vld_i, ptw_walk_resp_rdy_i,
        input  ptw_req_rdy_o, ptw_walk_req_vld_o, ptw_walk_req_id_o, ptw_walk_req_addr_o,
        input  replay_req_rdy_o, l1d_req_vld_o, l1d_req_id_o, l1d_req_paddr_o, l1d_req_is_replay_o
    );

    modport slave (
        input  ptw_req_vld_i, ptw_req_id_i, ptw_req_paddr_i,
        input  replay_req_vld_i, replay_req_id_i, replay_req_paddr_i,
        input  l1d_req_rdy_i, ptw_walk_resp_vld_i, ptw_walk_resp_rdy_i,
        output ptw_req_rdy_o, ptw_walk_req_vld_o, ptw_walk_req_id_o, ptw_walk_req_addr_o,
        output replay_req_rdy_o, l1d_req_vld_o, l1d_req_id_o, l1d_req_paddr_o, l1d_req_is_replay_o
    );
endinterface

// File: rtl/rvh_l1d_ptw_req_arb.sv
// rvh_l1d_ptw_req_arb: issues one PTW walk at a time to L1D and re-issues replays until the walk response
module rvh_l1d_ptw_req_arb #(
    parameter int PTW_ID_WIDTH   = 4,
    parameter int PADDR_WIDTH    = 56,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    rvh_l1d_ptw_req_arb_if.slave bus,
    output logic [3:0]          replay_cnt_o,
    output logic                err_timeout_o
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, NEW_ISSUE, WAIT_RESP, RPL_ISSUE} state_e;

    state_e                  state_q, state_d;
    logic                    vld_q, is_rpl_q, err_q, err_d;
    logic [PTW_ID_WIDTH-1:0] id_q;
    logic [PADDR_WIDTH-1:0]  paddr_q;
    logic [3:0]              cnt_q, cnt_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    resp_hs, l1d_hs, cap_new, cap_rpl, ptw_rdy, rpl_rdy, wd_clr, wd_run;

    assign resp_hs = bus.ptw_walk_resp_vld_i & bus.ptw_walk_resp_rdy_i;
    assign l1d_hs  = vld_q & bus.l1d_req_rdy_i;

    always_comb begin
        state_d = state_q;
        ptw_rdy = 1'b0;
        rpl_rdy = 1'b0;
        cap_new = 1'b0;
        cap_rpl = 1'b0;
        case (state_q)
            IDLE: begin
                ptw_rdy = 1'b1;
                cap_new = bus.ptw_req_vld_i;
                state_d = bus.ptw_req_vld_i ? NEW_ISSUE : IDLE;
            end
            NEW_ISSUE: state_d = bus.l1d_req_rdy_i ? WAIT_RESP : NEW_ISSUE;
            WAIT_RESP: begin
                // a response in the same cycle as a replay request wins; the replay is dropped
                rpl_rdy = ~resp_hs;
                cap_rpl = ~resp_hs & bus.replay_req_vld_i;
                state_d = resp_hs ? IDLE : cap_rpl ? RPL_ISSUE : WAIT_RESP;
            end
            default: state_d = resp_hs ? IDLE : bus.l1d_req_rdy_i ? WAIT_RESP : RPL_ISSUE;
        endcase
    end

    assign cnt_d = cap_new ? 4'd0 : (cap_rpl && cnt_q != 4'hf) ? cnt_q + 4'd1 : cnt_q;

    // the watchdog saturates at its last value; the error flag is sticky until reset
    assign wd_clr = l1d_hs | resp_hs | (state_d == IDLE);
    assign wd_run = (state_q != IDLE) & ~wd_clr;
    assign wd_d   = wd_clr ? '0 : (wd_run && wd_q != WD_MAX) ? wd_q + 1'b1 : wd_q;
    assign err_d  = err_q | (wd_run & (wd_q == WD_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vld_q    <= 1'b0;
            is_rpl_q <= 1'b0;
            cnt_q    <= 4'd0;
            wd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vld_q    <= (state_d == NEW_ISSUE) | (state_d == RPL_ISSUE);
            is_rpl_q <= cap_new ? 1'b0 : cap_rpl ? 1'b1 : is_rpl_q;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_new | cap_rpl) begin
            id_q    <= cap_new ? bus.ptw_req_id_i : bus.replay_req_id_i;
            paddr_q <= cap_new ? bus.ptw_req_paddr_i : bus.replay_req_paddr_i;
        end
    end

    assign bus.ptw_req_rdy_o       = ptw_rdy;
    assign bus.ptw_walk_req_vld_o  = bus.ptw_req_vld_i & ptw_rdy;
    assign bus.ptw_walk_req_id_o   = bus.ptw_req_id_i;
    assign bus.ptw_walk_req_addr_o = bus.ptw_req_paddr_i;
    assign bus.replay_req_rdy_o    = rpl_rdy;
    assign bus.l1d_req_vld_o       = vld_q;
    assign bus.l1d_req_id_o        = id_q;
    assign bus.l1d_req_paddr_o     = paddr_q;
    assign bus.l1d_req_is_replay_o = is_rpl_q;
    assign replay_cnt_o            = cnt_q;
    assign err_timeout_o           = err_q;

`ifndef SYNTHESIS
    a_no_early_resp: assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE || state_q == NEW_ISSUE) |-> !resp_hs);
    a_no_early_rpl: assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE || state_q == NEW_ISSUE) |-> !bus.replay_req_vld_i);
`endif
endmodule
